// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: default frame marker,
// default inter-byte timeout and the parser state encoding.
package uart_frame_parser_pkg;

  localparam logic [7:0]  SOF_BYTE_DEF      = 8'hA5;
  localparam int unsigned TIMEOUT_TICKS_DEF = 640;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4
  } state_e;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and payload/command output bundle of the frame parser.
//   rx_done_tick/din/s_tick : receiver byte strobe, byte, 16x sample tick
//   wr_en/wr_addr/wr_data   : payload buffer write port
//   cmd_valid/cmd/cmd_len   : accepted-frame report
//   frame_err/busy          : abort pulse, frame-in-progress flag
// master drives the byte stream, slave is the parser.
interface uart_frame_parser_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              rx_done_tick;
  logic [7:0]        din;
  logic              s_tick;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cmd_valid;
  logic [7:0]        cmd;
  logic [7:0]        cmd_len;
  logic              frame_err;
  logic              busy;

  modport master (
    output rx_done_tick, din, s_tick,
    input  wr_en, wr_addr, wr_data, cmd_valid, cmd, cmd_len, frame_err, busy
  );

  modport slave (
    input  rx_done_tick, din, s_tick,
    output wr_en, wr_addr, wr_data, cmd_valid, cmd, cmd_len, frame_err, busy
  );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts ticks while enabled, flags the terminal tick.
//   clk, reset : clock, async active-high reset
//   clr        : clear the count (dominates tick)
//   en, tick   : count one tick when both high
//   expired_c  : combinational, high on the tick that reaches TIMEOUT_TICKS
module uart_byte_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Count update; a clear in the same cycle as the terminal tick suppresses expiry.
  always_comb begin
    count_d   = count_q;
    expired_c = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en && tick) begin
      if (count_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
        expired_c = 1'b1;
        count_d   = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles received bytes into SOF/CMD/LEN/payload/XOR-checksum frames,
// writes payload bytes to the buffer and reports accepted or aborted frames.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of uart_frame_parser_if (byte stream in,
//                payload write port and frame status out, all registered)
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned ADDR_W        = 6,
  parameter logic [7:0]  SOF_BYTE      = SOF_BYTE_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_frame_parser_if.slave       bus
);

  localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        cmd_work_q, cmd_work_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              timeout_c;

  // Watchdog runs only inside a frame and restarts on every byte.
  uart_byte_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.rx_done_tick || (state_q == ST_IDLE)),
    .en       (state_q != ST_IDLE),
    .tick     (bus.s_tick),
    .expired_c(timeout_c)
  );

  // Next-state and output logic; a byte always takes priority over expiry.
  always_comb begin
    state_d     = state_q;
    cmd_work_d  = cmd_work_q;
    len_d       = len_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    cmd_len_d   = cmd_len_q;
    frame_err_d = 1'b0;

    if (bus.rx_done_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.din == SOF_BYTE) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_work_d = bus.din;
          chk_d      = bus.din;
          state_d    = ST_LEN;
        end
        ST_LEN: begin
          chk_d = chk_q ^ bus.din;
          len_d = bus.din;
          if (32'(bus.din) > MAX_LEN) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (bus.din == 8'd0) begin
            state_d = ST_CHK;
          end else begin
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = bus.din;
          chk_d     = chk_q ^ bus.din;
          idx_d     = idx_q + ADDR_W'(1);
          // idx is 0-based, so the last byte arrives at idx == len-1.
          if (32'(idx_q) == 32'(len_q) - 32'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          if (bus.din == chk_q) begin
            cmd_valid_d = 1'b1;
            cmd_d       = cmd_work_q;
            cmd_len_d   = len_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_work_q  <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_len_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_work_q  <= cmd_work_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_len_q   <= cmd_len_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
